// File: rtl/iob_mem_responder.sv
// IOb native-bus memory subordinate: word-addressed RAM with byte-enable writes,
// a fixed-latency read pipeline and a busy counter that spaces out accepted accesses.
module iob_mem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1,
    parameter int WAIT_N = 0
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic                avalid_i,
    input  logic [31:0]         addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rvalid_o,
    output logic                ready_o
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int RD_SPAN = (RD_LAT > WAIT_N) ? RD_LAT : WAIT_N;

    // A read reopens the bus in the cycle RD_SPAN after acceptance, which is the
    // rvalid cycle when WAIT_N <= RD_LAT; a write keeps it closed for WAIT_N cycles.
    localparam logic [3:0] RD_LOAD = 4'(RD_SPAN - 1);
    localparam logic [3:0] WR_LOAD = 4'(WAIT_N);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic              acc;
    logic              rd_acc;
    logic              wr_acc;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic [RD_LAT-1:0] pipe_vld_q;
    logic [DATA_W-1:0] pipe_data_q [RD_LAT];
    logic              unused_addr;

    assign word_idx    = addr_i[ADDR_W+1:2];
    assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

    assign ready_o = (cnt_q == 4'd0);
    assign acc     = avalid_i & ready_o & cke_i;
    assign rd_acc  = acc & (wstrb_i == '0);
    assign wr_acc  = acc & (wstrb_i != '0);

    always_comb begin
        // NOTE: default first so every path assigns cnt_d; otherwise a latch is inferred.
        cnt_d = cnt_q;
        if (rd_acc) begin
            cnt_d = RD_LOAD;
        end else if (wr_acc) begin
            cnt_d = WR_LOAD;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q <= 4'd0;
        end else if (cke_i) begin
            cnt_q <= cnt_d;
        end
    end

    // NOTE: the array has no reset; clearing it would cost a sweep, and contents must survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            for (int k = 0; k < NB; k++) begin
                if (wstrb_i[k]) begin
                    mem_q[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Data stages only move with a valid token, so the last stage holds between strobes.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else if (cke_i) begin
            pipe_vld_q[0] <= rd_acc;
            if (rd_acc) begin
                pipe_data_q[0] <= mem_q[word_idx];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                if (pipe_vld_q[i-1]) begin
                    pipe_data_q[i] <= pipe_data_q[i-1];
                end
            end
        end
    end

    assign rvalid_o = pipe_vld_q[RD_LAT-1];
    assign rdata_o  = pipe_data_q[RD_LAT-1];

endmodule

// File: tb/tb_iob_mem_responder.sv
// Bench for iob_mem_responder: four configurations share one stimulus bus, each
// checked every cycle against a time-based model, plus directed literal checks.
module tb_iob_mem_responder;

    localparam int N_INST = 4;

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          known;
    } rd_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        cke    = 1'b1;
    logic        avalid = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] wdata  = '0;
    logic [3:0]  wstrb  = '0;

    logic [N_INST-1:0] ready_w;
    logic [N_INST-1:0] rvalid_w;
    logic [31:0]       rdata_w [N_INST];

    int cyc     = 0;
    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Instances: 0:(RD_LAT 2, WAIT_N 0) 1:(1,3) 2:(3,0) 3:(4,0)
    for (genvar g = 0; g < N_INST; g++) begin : gi
        localparam int L  = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 4;
        localparam int W  = (g == 1) ? 3 : 0;
        localparam int MX = (L > W) ? L : W;

        iob_mem_responder #(
            .DATA_W(32), .ADDR_W(10), .RD_LAT(L), .WAIT_N(W)
        ) u_dut (
            .clk_i   (clk),
            .arst_n_i(rst_n),
            .cke_i   (cke),
            .avalid_i(avalid),
            .addr_i  (addr),
            .wdata_i (wdata),
            .wstrb_i (wstrb),
            .rdata_o (rdata_w[g]),
            .rvalid_o(rvalid_w[g]),
            .ready_o (ready_w[g])
        );

        // Model time t advances only on enabled edges; the bus is free once t reaches busy_until.
        int          t          = 0;
        int          busy_until = 0;
        int          w;
        rd_t         q[$];
        logic [31:0] mm [1024];
        bit          kn [1024];
        logic [31:0] last       = '0;
        bit          last_kn    = 1'b1;
        bit          rv_e;

        initial forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                t = 0; busy_until = 0; q.delete(); last = '0; last_kn = 1'b1;
            end else if (cke) begin
                if (q.size() > 0 && q[0].due == t) begin
                    last = q[0].data; last_kn = q[0].known;
                    void'(q.pop_front());
                end
                if (avalid && t >= busy_until) begin
                    w = int'((addr >> 2) % 32'd1024);
                    if (wstrb == 4'h0) begin
                        q.push_back('{due: t + L, data: mm[w], known: kn[w]});
                        busy_until = t + MX;
                    end else begin
                        for (int k = 0; k < 4; k++)
                            if (wstrb[k]) mm[w][8*k +: 8] = wdata[8*k +: 8];
                        if (wstrb == 4'hF) kn[w] = 1'b1;
                        busy_until = t + W + 1;
                    end
                end
                t++;
            end
        end

        initial forever begin
            @(negedge clk);
            rv_e = (q.size() > 0 && q[0].due == t);
            check($sformatf("u%0d ready", g), 32'(ready_w[g]), 32'(t >= busy_until));
            check($sformatf("u%0d rvalid", g), 32'(rvalid_w[g]), 32'(rv_e));
            if (rv_e) begin
                if (q[0].known) check($sformatf("u%0d rdata", g), rdata_w[g], q[0].data);
            end else if (last_kn) begin
                check($sformatf("u%0d rdata_hold", g), rdata_w[g], last);
            end
        end
    end

    // rvalid capture for instance 2 during the back-to-back run
    bit          mon_en = 1'b0;
    int          rv_cyc[$];
    logic [31:0] rv_dat[$];
    initial forever begin
        @(negedge clk);
        if (mon_en && rvalid_w[2]) begin
            rv_cyc.push_back(cyc);
            rv_dat.push_back(rdata_w[2]);
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (&ready_w) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Single-cycle request presented while every instance is ready; returns one cycle later.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok;
        wait_ready(ok);
        check("issue_ready_timeout", 32'(ok), 32'd1);
        avalid = 1'b1; addr = a; wdata = d; wstrb = s;
        @(negedge clk);
        avalid = 1'b0; wstrb = 4'h0;
    endtask

    task automatic observe(input int g, output int lat, output int low, output logic [31:0] data);
        bit seen_ready = 1'b0;
        lat = 0; low = 0; data = '0;
        for (int k = 1; k <= 10; k++) begin
            if (rvalid_w[g] && lat == 0) begin
                lat  = k;
                data = rdata_w[g];
            end
            if (!ready_w[g] && !seen_ready) low++;
            else seen_ready = 1'b1;
            if (k < 10) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, low, n, cnt;
        logic [31:0] d;
        int          acc_cyc[3];
        logic [31:0] b2b_exp[3];
        bit          ok;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < N_INST; g++) begin
            check("reset_ready", 32'(ready_w[g]), 32'd1);
            check("reset_rvalid", 32'(rvalid_w[g]), 32'd0);
            check("reset_rdata", rdata_w[g], 32'h0);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Basic write then read, RD_LAT=2
        issue(32'h10, 32'hDEADBEEF, 4'hF);
        issue(32'h10, 32'h0, 4'h0);
        observe(0, lat, low, d);
        check("rd_latency_u0", 32'(lat), 32'd2);
        check("rd_ready_low_u0", 32'(low), 32'd1);
        check("rd_data_u0", d, 32'hDEADBEEF);

        // Byte strobes
        issue(32'h20, 32'h11223344, 4'hF);
        issue(32'h20, 32'hAABBCCDD, 4'h5);
        issue(32'h20, 32'h0, 4'h0);
        observe(0, lat, low, d);
        check("strobe_data", d, 32'h11BB33DD);

        // Wait states on instance 1
        issue(32'h50, 32'h0, 4'hF);
        observe(1, lat, low, d);
        check("wr_ready_low_u1", 32'(low), 32'd3);
        check("wr_no_strobe_u1", 32'(lat), 32'd0);
        issue(32'h50, 32'h0, 4'h0);
        observe(1, lat, low, d);
        check("rd_latency_u1", 32'(lat), 32'd1);
        check("rd_ready_low_u1", 32'(low), 32'd2);

        // Request held while instance 1 is busy must not land there
        issue(32'h30, 32'h01010101, 4'hF);
        issue(32'h34, 32'h0, 4'hF);
        avalid = 1'b1; addr = 32'h30; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        repeat (3) @(negedge clk);
        avalid = 1'b0; wstrb = 4'h0;
        issue(32'h30, 32'h0, 4'h0);
        observe(1, lat, low, d);
        check("busy_ignored_u1", d, 32'h01010101);

        // Back-to-back reads on instance 2
        b2b_exp[0] = 32'h000000A0; b2b_exp[1] = 32'h000000A4; b2b_exp[2] = 32'h000000A8;
        issue(32'h0, b2b_exp[0], 4'hF);
        issue(32'h4, b2b_exp[1], 4'hF);
        issue(32'h8, b2b_exp[2], 4'hF);
        wait_ready(ok);
        mon_en = 1'b1;
        n = 0;
        avalid = 1'b1; addr = 32'h0; wstrb = 4'h0;
        for (int it = 0; it < 30; it++) begin
            if (ready_w[2]) begin
                acc_cyc[n] = cyc;
                n++;
                @(negedge clk);
                if (n == 3) begin
                    avalid = 1'b0;
                    break;
                end
                addr = 32'(4 * n);
            end else begin
                @(negedge clk);
            end
        end
        avalid = 1'b0;
        repeat (6) @(negedge clk);
        mon_en = 1'b0;
        check("b2b_accepts", 32'(n), 32'd3);
        check("b2b_strobes", 32'(rv_cyc.size()), 32'd3);
        if (n == 3) begin
            check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end
        for (int i = 0; i < 3; i++) begin
            if (i < rv_cyc.size() && i < n) begin
                check("b2b_latency", 32'(rv_cyc[i] - acc_cyc[i]), 32'd3);
                check("b2b_data", rv_dat[i], b2b_exp[i]);
            end
        end

        // Reset one cycle after read acceptance on instance 3
        issue(32'h40, 32'hCAFEF00D, 4'hF);
        issue(32'h40, 32'h0, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(ready_w[3]), 32'd1);
        check("midrst_rvalid", 32'(rvalid_w[3]), 32'd0);
        check("midrst_rdata", rdata_w[3], 32'h0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rvalid_w[3]) cnt++;
        end
        check("midrst_no_strobe", 32'(cnt), 32'd0);
        check("midrst_ready_after", 32'(ready_w[3]), 32'd1);
        issue(32'h40, 32'h0, 4'h0);
        observe(3, lat, low, d);
        check("midrst_latency_u3", 32'(lat), 32'd4);
        check("midrst_mem_kept", d, 32'hCAFEF00D);

        // Address aliasing and clock enable
        issue(32'h0000_1004, 32'h5A5A5A5A, 4'hF);
        issue(32'h4, 32'h0, 4'h0);
        observe(0, lat, low, d);
        check("alias_data", d, 32'h5A5A5A5A);
        issue(32'h4, 32'h0, 4'h0);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            if (rvalid_w[0] && lat == 0) lat = k;
            if (k == 1) cke = 1'b0;
            if (k == 6) cke = 1'b1;
            @(negedge clk);
        end
        check("cke_delay_u0", 32'(lat), 32'd7);

        wait_ready(ok);
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
